// File: rtl/gallery_match_pkg.sv
// gallery_match_pkg: shared FSM states and float32 ordering helpers for the gallery matcher.
package gallery_match_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, LAUNCH, WAIT_IP, UPDATE, FINISH} state_t;

    localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps float32 onto an unsigned key so that plain unsigned compare gives numeric order.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        return x[31] ? ~x : (x ^ 32'h8000_0000);
    endfunction

endpackage

// File: rtl/fp32_order_cmp.sv
// fp32_order_cmp: float32 a>b / a>=b using the order-preserving key transform.
module fp32_order_cmp
    import gallery_match_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt,
    output logic        ge
);

    assign gt = fp32_key(a) > fp32_key(b);
    assign ge = fp32_key(a) >= fp32_key(b);

endmodule

// File: rtl/gallery_match_ctrl.sv
// gallery_match_ctrl: walks the gallery through the cosine-similarity IP, tracks the best score
// and reports match against a threshold.
module gallery_match_ctrl
    import gallery_match_pkg::*;
#(
    parameter int D_Len     = 32,
    parameter int Ele_Num   = 128,
    parameter int GAL_DEPTH = 16,
    parameter int IDX_W     = 4,
    parameter int TIMEOUT   = 4096
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [D_Len*Ele_Num-1:0] probe,
    input  logic [IDX_W:0]           gal_count,
    input  logic [D_Len-1:0]         threshold,
    output logic                     gal_rd_en,
    output logic [IDX_W-1:0]         gal_addr,
    input  logic [D_Len*Ele_Num-1:0] gal_rdata,
    output logic                     ip_start,
    output logic [D_Len*Ele_Num-1:0] ip_vct1,
    output logic [D_Len*Ele_Num-1:0] ip_vct2,
    input  logic [D_Len-1:0]         ip_result,
    input  logic                     ip_done,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         best_idx,
    output logic [D_Len-1:0]         best_sim,
    output logic                     match,
    output logic                     err_empty,
    output logic                     err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(GAL_DEPTH);

    state_t state, nxt;
    logic [IDX_W:0] cnt, cnt_in;
    logic [IDX_W-1:0] idx;
    logic [D_Len-1:0] thr, res;
    logic [WD_W-1:0] wd;
    logic any_valid, match_q, last, wd_expired, upd_gt, thr_ge, m_now;
    logic upd_ge_unused, thr_gt_unused;

    assign cnt_in     = (gal_count > DEPTH) ? DEPTH : gal_count;
    assign last       = {1'b0, idx} == cnt - 1'b1;
    assign wd_expired = wd == WD_W'(TIMEOUT - 1);
    assign m_now      = any_valid & thr_ge & ~err_timeout;

    fp32_order_cmp u_upd (.a(res),      .b(best_sim), .gt(upd_gt),        .ge(upd_ge_unused));
    fp32_order_cmp u_thr (.a(best_sim), .b(thr),      .gt(thr_gt_unused), .ge(thr_ge));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? ((cnt_in == '0) ? FINISH : FETCH) : IDLE;
            FETCH:   nxt = WAIT_RD;
            WAIT_RD: nxt = LAUNCH;
            LAUNCH:  nxt = WAIT_IP;
            WAIT_IP: nxt = ip_done ? UPDATE : (wd_expired ? FINISH : WAIT_IP);
            UPDATE:  nxt = last ? FINISH : FETCH;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
        gal_rd_en = state == FETCH;
        ip_start  = state == LAUNCH;
        done      = state == FINISH;
        busy      = state != IDLE;
        gal_addr  = idx;
        // Present the verdict alongside the done pulse, then hold the registered copy.
        match     = match_q | (done & m_now);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ip_vct1     <= '0;
            ip_vct2     <= '0;
            cnt         <= '0;
            thr         <= '0;
            res         <= '0;
            idx         <= '0;
            wd          <= '0;
            any_valid   <= 1'b0;
            match_q     <= 1'b0;
            best_idx    <= '0;
            best_sim    <= '0;
            err_empty   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                ip_vct1     <= probe;
                cnt         <= cnt_in;
                thr         <= threshold;
                match_q     <= 1'b0;
                err_empty   <= cnt_in == '0;
                err_timeout <= 1'b0;
                best_sim    <= FP32_NEG_INF;
                best_idx    <= '0;
                idx         <= '0;
                any_valid   <= 1'b0;
            end
            if (state == WAIT_RD) ip_vct2 <= gal_rdata;
            if (state == LAUNCH) wd <= '0;
            if (state == WAIT_IP) begin
                if (ip_done)         res <= ip_result;
                else if (wd_expired) err_timeout <= 1'b1;
                else                 wd <= wd + 1'b1;
            end
            // NaN scores are skipped; strict compare keeps the lowest index on ties.
            if (state == UPDATE) begin
                if (!fp32_is_nan(res)) begin
                    any_valid <= 1'b1;
                    if (upd_gt) begin
                        best_sim <= res;
                        best_idx <= idx;
                    end
                end
                if (!last) idx <= idx + 1'b1;
            end
            if (state == FINISH) match_q <= m_now;
        end
    end

endmodule

// File: tb/tb_gallery_match_ctrl.sv
// tb_gallery_match_ctrl: randomized self-checking bench with a behavioural gallery RAM, IP model
// and a float-ordering reference search.
module tb_gallery_match_ctrl;

    localparam int V = 32 * 128;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [V-1:0] probe = '0, gal_rdata = '0, ip_vct1, ip_vct2;
    logic [4:0] gal_count = '0;
    logic [31:0] threshold = '0, ip_result = '0, best_sim;
    logic gal_rd_en, ip_start, ip_done = 1'b0, busy, done, match, err_empty, err_timeout;
    logic [3:0] gal_addr, best_idx;

    int n_chk = 0, n_err = 0;
    int n_rd = 0, n_ips = 0, n_done = 0;
    int addr_q[$];

    logic [V-1:0] ram[16];
    logic [31:0] res_tbl[16];
    int lat_tbl[16];
    int hang_idx = -1;
    bit real_mode = 1'b0;

    int cur_idx = 0, lat = 0;
    bit pend = 1'b0;
    logic [31:0] res_hold = '0;

    gallery_match_ctrl #(.TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .probe(probe), .gal_count(gal_count),
        .threshold(threshold), .gal_rd_en(gal_rd_en), .gal_addr(gal_addr), .gal_rdata(gal_rdata),
        .ip_start(ip_start), .ip_vct1(ip_vct1), .ip_vct2(ip_vct2), .ip_result(ip_result),
        .ip_done(ip_done), .busy(busy), .done(done), .best_idx(best_idx), .best_sim(best_sim),
        .match(match), .err_empty(err_empty), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (gal_rd_en) begin
            gal_rdata <= ram[gal_addr];
            cur_idx   <= int'(gal_addr);
        end
    end

    // IP stand-in: cosine of identical vectors is 1.0, of a vector and its negation -1.0.
    always @(posedge clk) begin
        ip_done <= 1'b0;
        if (rst) pend <= 1'b0;
        else if (ip_start) begin
            if (cur_idx != hang_idx) begin
                pend     <= 1'b1;
                lat      <= lat_tbl[cur_idx];
                res_hold <= real_mode ? ((ip_vct2 == ip_vct1) ? 32'h3F80_0000 : 32'hBF80_0000)
                                      : res_tbl[cur_idx];
            end
        end else if (pend) begin
            if (lat == 0) begin
                ip_done   <= 1'b1;
                ip_result <= res_hold;
                pend      <= 1'b0;
            end else lat <= lat - 1;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (gal_rd_en) begin
                n_rd++;
                addr_q.push_back(int'(gal_addr));
            end
            if (ip_start) n_ips++;
            if (done) n_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Numeric order with -0 below +0: negatives below positives, larger negative magnitude is smaller.
    function automatic bit flt_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31];
        if (!a[31]) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    function automatic logic [31:0] pick();
        int s = $urandom_range(0, 7);
        return (s == 0) ? 32'h0000_0000 : (s == 1) ? 32'h8000_0000 : (s == 2) ? 32'h7FC0_0000 :
               (s == 3) ? 32'hFF80_0000 : (s == 4) ? 32'h3F80_0000 : (s == 5) ? 32'hBF00_0000 :
               32'($urandom);
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_strobes"}, {gal_rd_en, ip_start, gal_addr}, 0);
        chk({tag, "_result"}, {best_idx, best_sim, match, err_empty, err_timeout}, 0);
        chk({tag, "_vct"}, {ip_vct1 == '0, ip_vct2 == '0}, 2'b11);
    endtask

    task automatic run(input int n, input logic [31:0] thr, input bit poke);
        int ne, k, bi, cyc, c, rd0, ip0, dn0, q0;
        logic [31:0] best, r;
        logic [V-1:0] pr;
        bit valid, to, ok, em;
        pr = probe;
        ne = (n > 16) ? 16 : n;
        best = 32'hFF80_0000; bi = 0; valid = 0; to = 0; cyc = 2; k = ne;
        for (int i = 0; i < ne; i++) begin
            if (i == hang_idx) begin
                to = 1; k = i + 1;
                break;
            end
            r = real_mode ? ((ram[i] == pr) ? 32'h3F80_0000 : 32'hBF80_0000) : res_tbl[i];
            cyc += 6 + lat_tbl[i];
            if (r[30:23] == 8'hFF && r[22:0] != 0) continue;
            valid = 1;
            if (flt_lt(best, r)) begin
                best = r; bi = i;
            end
        end
        em = valid && !flt_lt(best, thr) && !to;
        rd0 = n_rd; ip0 = n_ips; dn0 = n_done; q0 = addr_q.size();
        @(negedge clk);
        gal_count = 5'(n); threshold = thr; start = 1'b1;
        c = 1;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (done) break;
            start = poke && (c % 5 == 0);
            if (poke) begin
                gal_count = 5'($urandom);
                threshold = $urandom;
            end
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        if (!to) chk("cycles", c, cyc);
        chk("best_idx", best_idx, bi);
        chk("best_sim", best_sim, best);
        chk("match", match, em);
        chk("err_timeout", err_timeout, to);
        chk("err_empty", err_empty, n == 0);
        chk("busy_at_done", busy, 1);
        chk("rd_count", n_rd - rd0, k);
        chk("ip_starts", n_ips - ip0, k);
        ok = 1;
        for (int j = 0; j < k; j++) if (addr_q[q0 + j] != j) ok = 0;
        chk("addr_seq", ok, 1);
        @(negedge clk);
        chk("busy_drop", busy, 0);
        chk("hold", {match, best_idx, best_sim}, {em, 4'(bi), best});
        repeat (3) @(negedge clk);
        chk("done_pulses", n_done - dn0, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            for (int w = 0; w < 128; w++) ram[i][w*32 +: 32] = $urandom;
            res_tbl[i] = 32'h0;
            lat_tbl[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table scenario with a tie at index 3 and a negative entry.
        res_tbl[0] = 32'h3F00_0000; res_tbl[1] = 32'h3F66_6666;
        res_tbl[2] = 32'hBF80_0000; res_tbl[3] = 32'h3F66_6666;
        for (int i = 0; i < 4; i++) lat_tbl[i] = i + 1;
        run(4, 32'h3F4C_CCCD, 0);

        real_mode = 1'b1;
        probe = {128{32'h3F80_0000}};
        for (int i = 0; i < 4; i++) ram[i] = (i == 2) ? probe : {128{32'hBF80_0000}};
        run(4, 32'h3F00_0000, 0);
        real_mode = 1'b0;

        run(0, 32'h0, 0);

        hang_idx = 1;
        res_tbl[0] = 32'h3E80_0000;
        run(3, 32'hBF80_0000, 0);
        hang_idx = -1;

        res_tbl[0] = 32'h7FC0_0000; res_tbl[1] = 32'h0000_0000;
        run(2, 32'h0000_0000, 0);

        for (int i = 0; i < 16; i++) begin
            res_tbl[i] = pick();
            lat_tbl[i] = $urandom_range(0, 3);
        end
        run(25, pick(), 0);
        run(6, pick(), 1);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) begin
                res_tbl[i] = pick();
                lat_tbl[i] = $urandom_range(0, 4);
            end
            run($urandom_range(1, 16), pick(), r % 4 == 1);
        end

        // Reset during WAIT_IP with a competing start: search aborts with no done pulse.
        begin
            int ip0, dn0, g;
            for (int i = 0; i < 4; i++) lat_tbl[i] = 3;
            ip0 = n_ips;
            @(negedge clk);
            gal_count = 5'd4; threshold = 32'h0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            g = 0;
            while (n_ips == ip0 && g < 50) begin
                @(negedge clk);
                g++;
            end
            chk("rst_reach_ip", n_ips - ip0, 1);
            @(negedge clk);
            dn0 = n_done;
            rst = 1'b1; start = 1'b1;
            @(negedge clk);
            chk_idle_zero("midrst");
            rst = 1'b0; start = 1'b0;
            repeat (10) @(negedge clk);
            chk("midrst_no_done", n_done - dn0, 0);
            chk_idle_zero("midrst_after");
        end

        run(3, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gallery_match_ctrl.md
Name: gallery_match_ctrl

Overview:
Scheduler that sequences the cosine-similarity core (IP) over a stored gallery of face embeddings. On start it latches a probe vector, fetches each gallery entry in turn, launches one IP computation per entry and tracks the best similarity and its index. It then compares the best score against a threshold and reports match/no-match. It sits between the SoC control registers / gallery RAM and the IP instance.

Parameters:
D_Len, 32, element width in bits (IEEE-754 float32)
Ele_Num, 128, elements per embedding
GAL_DEPTH, 16, maximum gallery entries
IDX_W, 4, index width; equals clog2(GAL_DEPTH)
TIMEOUT, 4096, maximum cycles to wait for ip_done before aborting

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a search; accepted only in IDLE
probe  in  D_Len*Ele_Num  probe embedding; sampled on the accepted start
gal_count  in  IDX_W+1  number of valid gallery entries; sampled on the accepted start; values above GAL_DEPTH are clamped to GAL_DEPTH
threshold  in  D_Len  float32 match threshold; sampled on the accepted start
gal_rd_en  out  1  gallery RAM read strobe
gal_addr  out  IDX_W  gallery RAM address
gal_rdata  in  D_Len*Ele_Num  gallery entry; valid exactly 1 cycle after gal_rd_en
ip_start  out  1  single-cycle launch pulse to the IP core
ip_vct1  out  D_Len*Ele_Num  latched probe
ip_vct2  out  D_Len*Ele_Num  latched gallery entry
ip_result  in  D_Len  IP similarity result; valid while ip_done is high
ip_done  in  1  IP completion flag
busy  out  1  high from the accepted start until done
done  out  1  single-cycle completion pulse
best_idx  out  IDX_W  index of the best-scoring entry
best_sim  out  D_Len  best similarity (float32)
match  out  1  best_sim >= threshold and at least one valid score
err_empty  out  1  gal_count was 0
err_timeout  out  1  IP did not finish within TIMEOUT cycles

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs 0 except best_sim=0. Latched probe/entry registers cleared. Reset asserted mid-search aborts immediately; no done pulse is produced.
- IDLE: start=1 latches probe, gal_count and threshold. It clears match/err flags, sets best_sim=0xFF800000 (-inf), best_idx=0, idx=0 and busy=1. If gal_count==0: go to FINISH with err_empty=1. Otherwise go to FETCH.
- start while busy: ignored; no queueing.
- FETCH: gal_rd_en=1, gal_addr=idx; go to WAIT_RD.
- WAIT_RD: capture gal_rdata into the ip_vct2 register; go to LAUNCH.
- LAUNCH: ip_start=1 for exactly one cycle; clear the watchdog; go to WAIT_IP.
- WAIT_IP: on ip_done=1, register ip_result and go to UPDATE. Otherwise increment the watchdog; on reaching TIMEOUT-1, set err_timeout=1 and go to FINISH. The partial best is retained.
- UPDATE:
  - If the result is NaN (exp=0xFF, mant!=0), skip it.
  - Else if key(result) > key(best_sim) (strictly greater), set best_sim=result and best_idx=idx. Ties keep the lowest index.
  - If idx==gal_count-1, go to FINISH. Else idx++ and go to FETCH.
- FINISH: match = any_valid && key(best_sim) >= key(threshold) && !err_timeout. done=1 for one cycle; busy=0 on the next cycle; return to IDLE.
- Result outputs hold their values until the next accepted start.
- Ordering key for float32 compare: if sign=1, key=~x; else key=x^0x80000000. Compare keys unsigned. Consequently +0 > -0 and -inf is the minimum.
- Per-entry latency: 4 + L cycles, where L is the IP compute time. Total from start to done: 1 + N*(4+L) + 1 cycles.
- ip_done held high from a previous run must not be consumed: it is only sampled in WAIT_IP, which is entered after ip_start.

Decomposition:
- Package gallery_match_pkg: state enum (IDLE, FETCH, WAIT_RD, LAUNCH, WAIT_IP, UPDATE, FINISH), FP32_NEG_INF=0xFF800000, an fp32_is_nan function and an fp32_key function.
- One sub-module fp32_order_cmp: combinational a/b to gt/ge using the key transform. It is reused for both the best-score update and the threshold compare.

Test Plan:
- Behavioural IP model returning 0x3F000000, 0x3F666666, 0xBF800000, 0x3F666666 for idx 0..3; gal_count=4; threshold=0x3F4CCCCD -> best_idx=1, best_sim=0x3F666666, match=1, done pulses once, ip_start pulses exactly 4 times.
- Real IP, gallery entry 2 identical to probe (all 0x3F800000), other entries are the negated vector -> best_idx=2, best_sim=0x3F800000, match=1.
- gal_count=0 -> done 2 cycles after start, err_empty=1, match=0, best_sim=0xFF800000, no gal_rd_en and no ip_start.
- Model never asserts ip_done on entry 1, TIMEOUT=64 -> err_timeout=1, match=0, best_idx=0 retained from entry 0, done pulses.
- Model returns 0x7FC00000 (NaN) for idx 0 and 0x00000000 for idx 1; threshold=0x00000000 -> best_idx=1, best_sim=0x00000000, match=1.
- rst asserted in WAIT_IP, then a second start issued mid-search -> immediate return to IDLE, all outputs 0, no done. Start pulsed while busy -> ignored, gal_addr sequence unchanged.
